uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO, an integrated baud prescaler and runtime-selectable frame format (parity on/off, even/odd, 1 or 2 stop bits).
- Accepts words over a valid/ready handshake, buffers up to FIFO_DEPTH of them, and serialises them back-to-back LSB-first onto Tx_out.
- Successor to the single-word transmitter. The host no longer holds data for the whole frame, and no external baud strobe is needed.

---
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, built-in baud prescaler and per-frame
// latched format (parity on/off, even/odd, one or two stop bits).
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           P_data,
  input  logic                            Data_valid,
  output logic                            Data_ready,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            STOP2,
  input  logic [PRESCALE_WIDTH-1:0]       Prescale,
  output logic                            Tx_out,
  output logic                            Busy,
  output logic                            Frame_done,
  output logic [$clog2(FIFO_DEPTH):0]     Fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam int unsigned TMR_W = PRESCALE_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
  logic                      par_q, par_d;
  logic                      par_en_q, par_en_d;
  logic                      stop2_q, stop2_d;
  logic [PRESCALE_WIDTH-1:0] baud_q, baud_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      ready_q, ready_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;

  logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     head;
  logic                      push;
  logic                      pop;
  logic                      launch;
  logic                      tmr_zero;
  logic [TMR_W-1:0]          bit_reload;
  logic [TMR_W-1:0]          stop_reload;
  logic [PRESCALE_WIDTH-1:0] baud_in;

  assign Data_ready = ready_q;
  assign Tx_out     = tx_q;
  assign Busy       = busy_q;
  assign Frame_done = done_q;
  assign Fifo_count = count_q;

  // FIFO storage; no reset needed since count/pointers gate every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= P_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      baud_q   <= PRESCALE_WIDTH'(1);
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    baud_d      = baud_q;
    pop         = 1'b0;
    launch      = 1'b0;
    head        = mem[rd_ptr_q];
    push        = Data_valid && ready_q;
    tmr_zero    = (tmr_q == '0);
    baud_in     = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
    bit_reload  = TMR_W'(baud_q) - TMR_W'(1);
    stop_reload = stop2_q ? ({baud_q, 1'b0} - TMR_W'(1)) : bit_reload;

    case (state_q)
      START: begin
        if (tmr_zero) begin
          state_d = DATA;
          tmr_d   = bit_reload;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DATA: begin
        if (tmr_zero) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tmr_d   = bit_reload;
            end else begin
              state_d = STOP;
              tmr_d   = stop_reload;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
            tmr_d   = bit_reload;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      PARITY: begin
        if (tmr_zero) begin
          state_d = STOP;
          tmr_d   = stop_reload;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      STOP: begin
        if (tmr_zero) state_d = IDLE;
        else          tmr_d   = tmr_q - TMR_W'(1);
      end
      default: ;
    endcase

    // Pop from IDLE or on the last stop cycle; re-latches the frame format
    launch = (count_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && tmr_zero));
    if (launch) begin
      pop      = 1'b1;
      state_d  = START;
      shreg_d  = head;
      par_d    = (^head) ^ PAR_TYP;
      par_en_d = PAR_EN;
      stop2_d  = STOP2;
      baud_d   = baud_in;
      tmr_d    = TMR_W'(baud_in) - TMR_W'(1);
      idx_d    = '0;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ready_d  = (count_d != CNT_W'(FIFO_DEPTH));

    // Outputs are registered from the next state so Tx_out never glitches
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (tmr_d == '0);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame timing/format, FIFO fill and ordering,
// prescaler latching and asynchronous reset.
module tb_uart_tx_fifo;

  logic        clk;
  logic        rst;
  logic [7:0]  P_data;
  logic        Data_valid;
  logic        Data_ready;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        STOP2;
  logic [15:0] Prescale;
  logic        Tx_out;
  logic        Busy;
  logic        Frame_done;
  logic [2:0]  Fifo_count;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .P_data(P_data), .Data_valid(Data_valid),
    .Data_ready(Data_ready), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .Prescale(Prescale), .Tx_out(Tx_out), .Busy(Busy), .Frame_done(Frame_done),
    .Fifo_count(Fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge just before the frame's first cycle
  task automatic check_frame(input string tag, input logic [7:0] w, input bit pen,
                             input bit pval, input int b, input int flen);
    logic [11:0] bits;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = w[i];
    if (pen) bits[9] = pval;
    for (int c = 0; c < flen; c++) begin
      @(negedge clk);
      chk1({tag, "_tx"}, Tx_out, bits[c / b]);
      chk1({tag, "_busy"}, Busy, 1'b1);
      chk1({tag, "_done"}, Frame_done, c == flen - 1);
    end
  endtask

  task automatic push(input logic [7:0] w);
    P_data     = w;
    Data_valid = 1'b1;
    @(negedge clk);
    Data_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Data_valid = 1'b0; P_data = 8'h00;
    PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 16'd4;
    @(negedge clk);
    chk1("rst_tx", Tx_out, 1'b1);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_ready", Data_ready, 1'b1);
    chk1("rst_done", Frame_done, 1'b0);
    chkn("rst_count", 32'(Fifo_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 0xA5, even parity, B=4 -> 44 cycles
    push(8'hA5);
    chk1("t1_tx_idle", Tx_out, 1'b1);
    chk1("t1_busy_idle", Busy, 1'b0);
    chkn("t1_count", 32'(Fifo_count), 1);
    check_frame("t1", 8'hA5, 1'b1, 1'b0, 4, 44);
    @(negedge clk);
    chk1("t1_end_busy", Busy, 1'b0);
    chk1("t1_end_tx", Tx_out, 1'b1);
    chk1("t1_end_done", Frame_done, 1'b0);
    chkn("t1_end_count", 32'(Fifo_count), 0);

    // 2: odd parity + two stops -> 48; parity off -> 40
    PAR_TYP = 1'b1; STOP2 = 1'b1;
    push(8'hA5);
    check_frame("t2a", 8'hA5, 1'b1, 1'b1, 4, 48);
    PAR_EN = 1'b0; STOP2 = 1'b0;
    push(8'hA5);
    check_frame("t2b", 8'hA5, 1'b0, 1'b0, 4, 40);

    // 3: fill FIFO behind a running frame, 5th word waits for a pop
    push(8'h0F);
    fork
      begin
        check_frame("t3_w0", 8'h0F, 1'b0, 1'b0, 4, 40);
        check_frame("t3_w1", 8'h11, 1'b0, 1'b0, 4, 40);
        check_frame("t3_w2", 8'h22, 1'b0, 1'b0, 4, 40);
        check_frame("t3_w3", 8'h33, 1'b0, 1'b0, 4, 40);
        check_frame("t3_w4", 8'h44, 1'b0, 1'b0, 4, 40);
        check_frame("t3_w5", 8'h55, 1'b0, 1'b0, 4, 40);
      end
      begin
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          P_data = words[k]; Data_valid = 1'b1;
          @(negedge clk);
        end
        P_data = 8'h55;
        chkn("t3_full_count", 32'(Fifo_count), 4);
        chk1("t3_full_ready", Data_ready, 1'b0);
        for (int i = 0; i < 100 && !Data_ready; i++) begin
          chkn("t3_hold_count", 32'(Fifo_count), 4);
          @(negedge clk);
        end
        chk1("t3_ready_reopen", Data_ready, 1'b1);
        chkn("t3_after_pop", 32'(Fifo_count), 3);
        @(negedge clk);
        Data_valid = 1'b0;
        chkn("t3_refill", 32'(Fifo_count), 4);
      end
    join

    // 4: Prescale=0 -> 10-cycle frame; prescale change mid-frame
    Prescale = 16'd0;
    push(8'h3C);
    check_frame("t4a", 8'h3C, 1'b0, 1'b0, 1, 10);
    Prescale = 16'd4;
    push(8'h96);
    fork
      begin
        check_frame("t4b", 8'h96, 1'b0, 1'b0, 4, 40);
        check_frame("t4c", 8'hC3, 1'b0, 1'b0, 8, 80);
      end
      begin
        push(8'hC3);
        repeat (10) @(negedge clk);
        Prescale = 16'd8;
      end
    join

    // 5: async reset mid-DATA with two words queued
    Prescale = 16'd4;
    push(8'h55);
    push(8'h66);
    push(8'h77);
    repeat (6) @(negedge clk);
    chk1("t5_pre_busy", Busy, 1'b1);
    chkn("t5_pre_count", 32'(Fifo_count), 2);
    #1 rst = 1'b1;
    #1;
    chk1("t5_tx", Tx_out, 1'b1);
    chk1("t5_busy", Busy, 1'b0);
    chkn("t5_count", 32'(Fifo_count), 0);
    chk1("t5_ready", Data_ready, 1'b1);
    chk1("t5_done", Frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("t5_quiet_tx", Tx_out, 1'b1);
      chk1("t5_quiet_busy", Busy, 1'b0);
    end
    Prescale = 16'd0;
    push(8'h81);
    check_frame("t5_new", 8'h81, 1'b0, 1'b0, 1, 10);

    // 6: push and pop on the same edge with two words queued
    push(8'hF0);
    fork
      begin
        check_frame("t6_f", 8'hF0, 1'b0, 1'b0, 1, 10);
        check_frame("t6_p", 8'h5A, 1'b0, 1'b0, 1, 10);
        check_frame("t6_q", 8'h3C, 1'b0, 1'b0, 1, 10);
        check_frame("t6_r", 8'hE7, 1'b0, 1'b0, 1, 10);
      end
      begin
        push(8'h5A);
        push(8'h3C);
        chkn("t6_count_a", 32'(Fifo_count), 2);
        repeat (8) @(negedge clk);
        chkn("t6_count_b", 32'(Fifo_count), 2);
        P_data = 8'hE7; Data_valid = 1'b1;
        @(negedge clk);
        Data_valid = 1'b0;
        chkn("t6_count_c", 32'(Fifo_count), 2);
      end
    join
    @(negedge clk);
    chk1("t6_end_busy", Busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
